calc_stack: RTL
===============

CALC_STACK -- requirements
Module: calc_stack

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand, accumulator and LED width; legal values are 4 to 32.
REQ-002 Parameter DEPTH, default 8, sets the undo-history entries; legal values are 2 to 64, power of two.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btnc, btnl, btnr  input  1 each  operation select levels; op = {btnl,btnc,btnr}.
REQ-006 btnd  input  1  execute request, rising-edge triggered.
REQ-007 btnu  input  1  clear request, rising-edge triggered.
REQ-008 sw  input  WIDTH  operand 2.
REQ-009 led  output  WIDTH  current accumulator value.
REQ-010 ovf  output  1  overflow result of the last completed operation.
REQ-011 busy  output  1  multiplication in progress.
REQ-012 hist_cnt  output  clog2(DEPTH+1)  number of valid undo entries.

Function
REQ-013 All button and sw inputs SHALL pass through a 2-flop synchroniser; btnd/btnu events SHALL be a one-cycle pulse on a synchronised 0->1 transition.
REQ-014 Cycle D is the cycle the event pulse is high; op and sw SHALL be taken from their synchronised values in cycle D.
REQ-015 With inputs held stable, the pin-to-pulse delay SHALL be 2 clocks, and a single-cycle result SHALL appear on led after the 3rd rising edge following the pin change.
REQ-016 Op 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR: new acc = acc op sw; WIDTH-bit two's complement, wrap-around.
REQ-017 Op 101 SRA: new acc = acc arithmetic-shifted right by sw[clog2(WIDTH)-1:0].
REQ-018 Single-cycle ops SHALL update acc and ovf at the end of cycle D, visible from D+1.
REQ-019 ovf SHALL be 1 on ADD/SUB signed overflow, 0 for AND/OR/XOR/SRA.
REQ-020 Op 110 MUL: unsigned shift-add of acc x sw, one multiplier bit per cycle.
REQ-021 MUL: busy=1 in cycles D+1..D+WIDTH; acc = low WIDTH product bits and busy=0 from D+WIDTH+1.
REQ-022 MUL: ovf=1 iff the upper WIDTH bits of the 2*WIDTH-bit product are non-zero.
REQ-023 Op 111 UNDO: pop the newest history entry into acc, with hist_cnt-1 and ovf=0.
REQ-024 UNDO with hist_cnt=0 SHALL change nothing.
REQ-025 Every completed non-UNDO op and every clear SHALL push the pre-operation acc to history, with hist_cnt+1.
REQ-026 History is circular: a push at hist_cnt=DEPTH SHALL overwrite the oldest entry, and hist_cnt SHALL stay at DEPTH.
REQ-027 A clear pulse SHALL set acc=0 and ovf=0 from D+1.
REQ-028 A clear while busy SHALL abort the MUL: busy=0, acc=0, and the pre-MUL acc is pushed.
REQ-029 Execute pulses while busy=1 SHALL be ignored; they are not queued.
REQ-030 Clear and execute pulses in the same cycle: clear SHALL win and execute SHALL be dropped.
REQ-031 led SHALL equal acc combinationally from the register, with no extra stage.

Reset
REQ-032 rst_n=0 SHALL immediately force acc=0, led=0, ovf=0, busy=0, hist_cnt=0, the MUL state to idle, and all synchroniser/edge flops to 0.
REQ-033 Asserting reset mid-MUL SHALL discard the operation; history contents need not be cleared, since hist_cnt=0 marks them invalid.
REQ-034 A button held across reset release SHALL produce exactly one event 2 clocks after release.

Verification (WIDTH=16, DEPTH=4)
REQ-035 Reset, op=010, sw=0x0005, raise btnd -> led=0x0005 after the 3rd edge, ovf=0, hist_cnt=1.
REQ-036 acc=0x7FFF, op=010, sw=0x0001, btnd -> led=0x8000, ovf=1; then op=000, sw=0xFF00, btnd -> led=0x8000, ovf=0.
REQ-037 acc=0x0003, op=110, sw=0x0004, btnd -> busy high exactly 16 cycles, then led=0x000C, ovf=0; a second btnd while busy -> no effect; acc=0x0100, sw=0x0100 -> led=0x0000, ovf=1.
REQ-038 From reset, ADD sw=1 five times -> led=5, hist_cnt=4; UNDO x4 -> led=4,3,2,1, hist_cnt=0; 5th UNDO -> led=1 unchanged.
REQ-039 acc=0x0009, btnu and btnd rise on the same cycle -> led=0x0000, hist_cnt+1, no ALU result; UNDO -> led=0x0009.
REQ-040 MUL in progress, rst_n pulsed low for 1 cycle -> led=0, busy=0, hist_cnt=0 during reset, with no late write after release.

Source files
------------

// File: rtl/calc_stack.sv
// calc_stack: button-driven accumulator calculator with an undo history.
//
// Ports
//   clk       : single clock, all state changes on its rising edge
//   rst_n     : asynchronous active-low reset
//   btnl/btnc/btnr : operation select levels, op = {btnl,btnc,btnr}
//   btnd      : execute request (rising-edge triggered)
//   btnu      : clear request (rising-edge triggered)
//   sw        : operand 2
//   led       : current accumulator value
//   ovf       : overflow flag of the last completed operation
//   busy      : shift-add multiplication in progress (mirrors the FSM state)
//   hist_cnt  : number of valid undo entries
//
// Ops: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SRA, 110 MUL, 111 UNDO.
//
// Handshake: there is no valid/ready pair here; btnd/btnu are level inputs
// whose synchronised 0->1 transitions become one-cycle event pulses. An execute
// pulse is accepted only while busy=0 and is dropped otherwise; a clear pulse is
// always accepted and takes priority over an execute pulse in the same cycle.
module calc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btnc,
  input  logic                       btnl,
  input  logic                       btnr,
  input  logic                       btnd,
  input  logic                       btnu,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       ovf,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int SW_BITS = WIDTH + 5;
  localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_UNDO = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and edge detection
  // ---------------------------------------------------------------------
  logic [SW_BITS-1:0] sync1_q, sync2_q;
  logic               btnd_prev_q, btnu_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btnd_prev_q <= 1'b0;
      btnu_prev_q <= 1'b0;
    end else begin
      sync1_q     <= {btnu, btnd, btnl, btnc, btnr, sw};
      sync2_q     <= sync1_q;
      btnd_prev_q <= sync2_q[WIDTH+3];
      btnu_prev_q <= sync2_q[WIDTH+4];
    end
  end

  logic [WIDTH-1:0] sw_s;
  logic [2:0]       op_s;
  logic             exec_pulse, clr_pulse;

  assign sw_s       = sync2_q[WIDTH-1:0];
  assign op_s       = sync2_q[WIDTH+2:WIDTH];
  assign exec_pulse = sync2_q[WIDTH+3] & ~btnd_prev_q;
  assign clr_pulse  = sync2_q[WIDTH+4] & ~btnu_prev_q;

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       bit_q, bit_d;
  logic [PW-1:0]        hist_ptr_q, hist_ptr_d;
  logic [CW-1:0]        hist_cnt_q, hist_cnt_d;
  logic [WIDTH-1:0]     hist_mem [DEPTH];
  logic                 hist_push;

  // Single-cycle ALU
  logic [WIDTH-1:0] add_res, sub_res, sra_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [2*WIDTH-1:0] prod_step;

  assign add_res   = acc_q + sw_s;
  assign sub_res   = acc_q - sw_s;
  assign sra_res   = $signed(acc_q) >>> sw_s[SHW-1:0];
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    case (op_s)
      OP_AND: alu_res = acc_q & sw_s;
      OP_OR:  alu_res = acc_q | sw_s;
      OP_XOR: alu_res = acc_q ^ sw_s;
      OP_SRA: alu_res = sra_res;
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (acc_q[WIDTH-1] == sw_s[WIDTH-1]) &&
                  (add_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (acc_q[WIDTH-1] != sw_s[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      default: begin
        alu_res = acc_q;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next-state logic. acc_q is left untouched while a MUL runs, so it still
  // holds the pre-operation value whenever history needs it pushed.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    bit_d      = bit_q;
    hist_ptr_d = hist_ptr_q;
    hist_cnt_d = hist_cnt_q;
    hist_push  = 1'b0;

    if (clr_pulse) begin
      acc_d     = '0;
      ovf_d     = 1'b0;
      state_d   = ST_IDLE;
      hist_push = 1'b1;
    end else if (state_q == ST_MUL) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      bit_d    = bit_q + SHW'(1);
      if (bit_q == LAST_BIT) begin
        acc_d     = prod_step[WIDTH-1:0];
        ovf_d     = |prod_step[2*WIDTH-1:WIDTH];
        state_d   = ST_IDLE;
        hist_push = 1'b1;
      end
    end else if (exec_pulse) begin
      case (op_s)
        OP_UNDO: begin
          if (hist_cnt_q != '0) begin
            acc_d      = hist_mem[hist_ptr_q - PW'(1)];
            ovf_d      = 1'b0;
            hist_ptr_d = hist_ptr_q - PW'(1);
            hist_cnt_d = hist_cnt_q - CW'(1);
          end
        end
        OP_MUL: begin
          state_d  = ST_MUL;
          mcand_d  = {{WIDTH{1'b0}}, acc_q};
          mplier_d = sw_s;
          prod_d   = '0;
          bit_d    = '0;
        end
        default: begin
          acc_d     = alu_res;
          ovf_d     = alu_ovf;
          hist_push = 1'b1;
        end
      endcase
    end

    // Pointer wraps modulo DEPTH, so a push on a full history overwrites the
    // oldest entry while the count saturates.
    if (hist_push) begin
      hist_ptr_d = hist_ptr_q + PW'(1);
      if (hist_cnt_q != CW'(DEPTH)) hist_cnt_d = hist_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      bit_q      <= '0;
      hist_ptr_q <= '0;
      hist_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mplier_q   <= mplier_d;
      bit_q      <= bit_d;
      hist_ptr_q <= hist_ptr_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  // History storage needs no reset: hist_cnt=0 marks every entry invalid.
  always_ff @(posedge clk) begin
    if (hist_push) hist_mem[hist_ptr_q] <= acc_q;
  end

  assign led      = acc_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == ST_MUL);
  assign hist_cnt = hist_cnt_q;

endmodule
